// File: rtl/id_ctrl_pipe.sv
// ID-stage decode/control for a 5-stage MIPS pipeline: decodes the opcode into a
// control bundle, carries it through EX/MEM/WB, and handles load-use stalls and branch flushes.
module id_ctrl_pipe #(
  parameter int REG_W   = 5,
  parameter int ALUOP_W = 3,
  parameter bit EXT_EN  = 1'b1,
  parameter int CNT_W   = 16,
  localparam int CTRL_W = ALUOP_W + 7
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              id_valid,
  input  logic [5:0]        id_opcode,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_rd,
  input  logic              ex_branch_taken,
  output logic              ex_valid,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [REG_W-1:0]  ex_dst,
  output logic              mem_valid,
  output logic [CTRL_W-1:0] mem_ctrl,
  output logic [REG_W-1:0]  mem_dst,
  output logic              wb_valid,
  output logic [CTRL_W-1:0] wb_ctrl,
  output logic [REG_W-1:0]  wb_dst,
  output logic              stall,
  output logic              flush,
  output logic              illegal_op,
  output logic [CNT_W-1:0]  stall_count
);

  typedef struct packed {
    logic               branch_ne;
    logic               branch;
    logic               mem_to_reg;
    logic               mem_read;
    logic               mem_write;
    logic               alu_src;
    logic               reg_write;
    logic [ALUOP_W-1:0] alu_op;
  } ctrl_t;

  typedef struct packed {
    logic             valid;
    ctrl_t            ctrl;
    logic [REG_W-1:0] dst;
  } stage_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LHU   = 6'b100101;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  ctrl_t            dec_ctrl;
  logic [REG_W-1:0] dec_dst;
  logic             dec_legal;
  logic             dec_rt_use;
  logic             hz;

  stage_t           ex_q, ex_d;
  stage_t           mem_q, mem_d;
  stage_t           wb_q, wb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ill_q, ill_d;

  // NOTE: every variable gets a default at the top of the block so no path leaves it unassigned (no latch).
  always_comb begin
    dec_ctrl   = '0;
    dec_dst    = '0;
    dec_legal  = 1'b1;
    dec_rt_use = 1'b0;
    unique case (id_opcode)
      OP_RTYPE: begin
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.alu_op    = ALUOP_W'(3'b100);
        dec_dst            = id_rd;
        dec_rt_use         = 1'b1;
      end
      OP_ADDI: begin
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.alu_src   = 1'b1;
        dec_dst            = id_rt;
      end
      OP_LW, OP_LH, OP_LHU: begin
        dec_ctrl.reg_write  = 1'b1;
        dec_ctrl.alu_src    = 1'b1;
        dec_ctrl.mem_read   = 1'b1;
        dec_ctrl.mem_to_reg = 1'b1;
        dec_dst             = id_rt;
      end
      OP_SW: begin
        dec_ctrl.alu_src   = 1'b1;
        dec_ctrl.mem_write = 1'b1;
        dec_rt_use         = 1'b1;
      end
      OP_BEQ: begin
        dec_ctrl.branch = 1'b1;
        dec_ctrl.alu_op = ALUOP_W'(3'b001);
        dec_rt_use      = 1'b1;
      end
      OP_BNE: begin
        if (EXT_EN) begin
          dec_ctrl.branch    = 1'b1;
          dec_ctrl.branch_ne = 1'b1;
          dec_ctrl.alu_op    = ALUOP_W'(3'b001);
          dec_rt_use         = 1'b1;
        end else begin
          dec_legal = 1'b0;
        end
      end
      OP_ANDI: begin
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.alu_src   = 1'b1;
        dec_ctrl.alu_op    = ALUOP_W'(3'b011);
        dec_dst            = id_rt;
      end
      OP_ORI: begin
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.alu_src   = 1'b1;
        dec_ctrl.alu_op    = ALUOP_W'(3'b010);
        dec_dst            = id_rt;
      end
      OP_SLTI: begin
        if (EXT_EN) begin
          dec_ctrl.reg_write = 1'b1;
          dec_ctrl.alu_src   = 1'b1;
          dec_ctrl.alu_op    = ALUOP_W'(3'b101);
          dec_dst            = id_rt;
        end else begin
          dec_legal = 1'b0;
        end
      end
      default: dec_legal = 1'b0;
    endcase
    // Writes to $zero are architecturally discarded, so drop them at the source.
    if (dec_dst == '0) dec_ctrl.reg_write = 1'b0;
  end

  assign hz = ex_q.valid && ex_q.ctrl.mem_read && (ex_q.dst != '0) && id_valid &&
              ((ex_q.dst == id_rs) || (dec_rt_use && (ex_q.dst == id_rt)));
  assign flush = ex_branch_taken;
  assign stall = hz && !ex_branch_taken;

  always_comb begin
    ex_d = '0;
    if (id_valid && dec_legal && !flush && !stall) begin
      ex_d.valid = 1'b1;
      ex_d.ctrl  = dec_ctrl;
      ex_d.dst   = dec_dst;
    end
    mem_d = ex_q;
    wb_d  = mem_q;
    cnt_d = (stall && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;
    ill_d = id_valid && !dec_legal && !flush && !stall;
  end

  // NOTE: state updates use non-blocking assignments; reset is sampled synchronously on the clock edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      cnt_q <= '0;
      ill_q <= 1'b0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
      cnt_q <= cnt_d;
      ill_q <= ill_d;
    end
  end

  assign ex_valid    = ex_q.valid;
  assign ex_ctrl     = ex_q.ctrl;
  assign ex_dst      = ex_q.dst;
  assign mem_valid   = mem_q.valid;
  assign mem_ctrl    = mem_q.ctrl;
  assign mem_dst     = mem_q.dst;
  assign wb_valid    = wb_q.valid;
  assign wb_ctrl     = wb_q.ctrl;
  assign wb_dst      = wb_q.dst;
  assign illegal_op  = ill_q;
  assign stall_count = cnt_q;

endmodule

// File: tb/tb_id_ctrl_pipe.sv
// Bench for id_ctrl_pipe: a default instance and an EXT_EN=0/CNT_W=2 instance share
// one stimulus stream and are compared against an opcode-table reference model.
module tb_id_ctrl_pipe;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       id_valid = 1'b0;
  logic [5:0] id_opcode = '0;
  logic [4:0] id_rs = '0, id_rt = '0, id_rd = '0;
  logic       ex_branch_taken = 1'b0;

  logic       ex_valid, mem_valid, wb_valid, stall, flush, illegal_op;
  logic [9:0] ex_ctrl, mem_ctrl, wb_ctrl;
  logic [4:0] ex_dst, mem_dst, wb_dst;
  logic [15:0] stall_count;

  logic       a_ex_valid, a_mem_valid, a_wb_valid, a_stall, a_flush, a_illegal_op;
  logic [9:0] a_ex_ctrl, a_mem_ctrl, a_wb_ctrl;
  logic [4:0] a_ex_dst, a_mem_dst, a_wb_dst;
  logic [1:0] a_stall_count;

  int checks = 0;
  int errors = 0;

  id_ctrl_pipe u_dut (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_branch_taken(ex_branch_taken),
    .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_dst(ex_dst),
    .mem_valid(mem_valid), .mem_ctrl(mem_ctrl), .mem_dst(mem_dst),
    .wb_valid(wb_valid), .wb_ctrl(wb_ctrl), .wb_dst(wb_dst),
    .stall(stall), .flush(flush), .illegal_op(illegal_op), .stall_count(stall_count)
  );

  id_ctrl_pipe #(.EXT_EN(1'b0), .CNT_W(2)) u_alt (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_branch_taken(ex_branch_taken),
    .ex_valid(a_ex_valid), .ex_ctrl(a_ex_ctrl), .ex_dst(a_ex_dst),
    .mem_valid(a_mem_valid), .mem_ctrl(a_mem_ctrl), .mem_dst(a_mem_dst),
    .wb_valid(a_wb_valid), .wb_ctrl(a_wb_ctrl), .wb_dst(a_wb_dst),
    .stall(a_stall), .flush(a_flush), .illegal_op(a_illegal_op), .stall_count(a_stall_count)
  );

  always #5 clk = ~clk;

  // Reference model: index 0 mirrors u_dut (extended ops, 16-bit count), index 1 mirrors u_alt.
  typedef struct packed {
    logic       v;
    logic [9:0] c;
    logic [4:0] d;
  } stage_t;

  stage_t      m_ex[2], m_mem[2], m_wb[2];
  int unsigned m_cnt[2];
  bit          m_ill[2];

  function automatic stage_t ref_decode(input logic [5:0] op, input logic [4:0] rt, input logic [4:0] rd,
                                        input bit ext, output bit ill);
    bit bne = 0, br = 0, m2r = 0, mr = 0, mw = 0, as = 0, rw = 0;
    logic [2:0] aop = 3'd0;
    logic [4:0] d = 5'd0;
    stage_t s;
    ill = 0;
    case (op)
      6'h00: begin rw = 1; d = rd; aop = 3'd4; end
      6'h08: begin rw = 1; as = 1; d = rt; end
      6'h23, 6'h21, 6'h25: begin rw = 1; as = 1; mr = 1; m2r = 1; d = rt; end
      6'h2b: begin as = 1; mw = 1; end
      6'h04: begin br = 1; aop = 3'd1; end
      6'h05: if (ext) begin br = 1; bne = 1; aop = 3'd1; end else ill = 1;
      6'h0c: begin rw = 1; as = 1; aop = 3'd3; d = rt; end
      6'h0d: begin rw = 1; as = 1; aop = 3'd2; d = rt; end
      6'h0a: if (ext) begin rw = 1; as = 1; aop = 3'd5; d = rt; end else ill = 1;
      default: ill = 1;
    endcase
    if (d == 0) rw = 0;
    s.v = !ill;
    s.c = {bne, br, m2r, mr, mw, as, rw, aop};
    s.d = d;
    return s;
  endfunction

  function automatic bit ref_rt_use(input logic [5:0] op, input bit ext);
    return (op == 6'h00) || (op == 6'h2b) || (op == 6'h04) || (ext && op == 6'h05);
  endfunction

  function automatic bit ref_stall(input int k);
    bit hz;
    hz = m_ex[k].v && m_ex[k].c[6] && (m_ex[k].d != 0) && id_valid &&
         ((m_ex[k].d == id_rs) || (ref_rt_use(id_opcode, k == 0) && (m_ex[k].d == id_rt)));
    return hz && !ex_branch_taken;
  endfunction

  function automatic logic [66:0] exp_vec(input int k);
    return {m_ex[k], m_mem[k], m_wb[k], ref_stall(k), ex_branch_taken, m_ill[k], 16'(m_cnt[k])};
  endfunction

  function automatic logic [66:0] obs_vec(input int k);
    if (k == 0)
      return {ex_valid, ex_ctrl, ex_dst, mem_valid, mem_ctrl, mem_dst, wb_valid, wb_ctrl, wb_dst,
              stall, flush, illegal_op, stall_count};
    return {a_ex_valid, a_ex_ctrl, a_ex_dst, a_mem_valid, a_mem_ctrl, a_mem_dst, a_wb_valid, a_wb_ctrl,
            a_wb_dst, a_stall, a_flush, a_illegal_op, 14'd0, a_stall_count};
  endfunction

  // Advance one clock: evaluate the model on the current inputs, then commit at the edge.
  task automatic tick();
    stage_t nx_ex[2];
    int unsigned nx_cnt[2];
    bit nx_ill[2];
    for (int k = 0; k < 2; k++) begin
      bit ill, st;
      stage_t dec;
      dec = ref_decode(id_opcode, id_rt, id_rd, k == 0, ill);
      st  = ref_stall(k);
      nx_ex[k]  = (!id_valid || ill || st || ex_branch_taken) ? '0 : dec;
      nx_ill[k] = id_valid && ill && !st && !ex_branch_taken;
      nx_cnt[k] = (st && m_cnt[k] < ((k == 0) ? 65535 : 3)) ? m_cnt[k] + 1 : m_cnt[k];
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (!reset_n) begin
        m_ex[k] = '0; m_mem[k] = '0; m_wb[k] = '0; m_cnt[k] = 0; m_ill[k] = 0;
      end else begin
        m_wb[k] = m_mem[k]; m_mem[k] = m_ex[k]; m_ex[k] = nx_ex[k];
        m_cnt[k] = nx_cnt[k]; m_ill[k] = nx_ill[k];
      end
    end
    #1;
  endtask

  task automatic drive(input bit v, input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input bit tk);
    id_valid = v; id_opcode = op; id_rs = rs; id_rt = rt; id_rd = rd; ex_branch_taken = tk;
  endtask

  task automatic do_reset();
    drive(0, 6'h00, 0, 0, 0, 0);
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1, 6'h23, 5'd1, 5'd3, 5'd0, 0);
      tick();
    end
    reset_n = 1'b0;
    drive(1, 6'h23, 5'd3, 5'd3, 5'd0, 0);
    tick();
    tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs_vec(k) !== 67'd0) begin
        errors++;
        $display("FAIL reset inst%0d: got %h expected 0", k, obs_vec(k));
      end
    end
    reset_n = 1'b1;
  endtask

  task automatic test_addi();
    do_reset();
    drive(1, 6'h08, 5'd1, 5'd5, 5'd0, 0);
    tick();
    drive(0, 6'h00, 0, 0, 0, 0);
    checks++;
    if ({ex_valid, ex_ctrl, ex_dst} !== {1'b1, 10'b0000011000, 5'd5}) begin
      errors++;
      $display("FAIL addi_ex: got %b %b %0d expected 1 0000011000 5", ex_valid, ex_ctrl, ex_dst);
    end
    tick();
    checks++;
    if ({mem_valid, mem_ctrl, mem_dst} !== {1'b1, 10'b0000011000, 5'd5}) begin
      errors++;
      $display("FAIL addi_mem: got %b %b %0d expected 1 0000011000 5", mem_valid, mem_ctrl, mem_dst);
    end
    tick();
    checks++;
    if ({wb_valid, wb_ctrl, wb_dst, ex_valid} !== {1'b1, 10'b0000011000, 5'd5, 1'b0}) begin
      errors++;
      $display("FAIL addi_wb: got %b %b %0d ex=%b expected 1 0000011000 5 ex=0",
               wb_valid, wb_ctrl, wb_dst, ex_valid);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    drive(1, 6'h23, 5'd1, 5'd3, 5'd0, 0);
    tick();
    drive(1, 6'h00, 5'd3, 5'd4, 5'd6, 0);
    #1;
    checks++;
    if ({stall, flush} !== 2'b10) begin
      errors++;
      $display("FAIL lu_stall: got stall=%b flush=%b expected 1 0", stall, flush);
    end
    tick();
    checks++;
    if ({ex_valid, ex_ctrl, ex_dst, stall} !== 17'd0) begin
      errors++;
      $display("FAIL lu_bubble: got ex_valid=%b ctrl=%b dst=%0d stall=%b expected all 0",
               ex_valid, ex_ctrl, ex_dst, stall);
    end
    tick();
    drive(0, 6'h00, 0, 0, 0, 0);
    checks++;
    if ({ex_valid, ex_dst, stall_count} !== {1'b1, 5'd6, 16'd1}) begin
      errors++;
      $display("FAIL lu_resume: got ex_valid=%b dst=%0d cnt=%0d expected 1 6 1", ex_valid, ex_dst, stall_count);
    end
    // rt of ORI is its destination, not a source, so no hazard on rt.
    do_reset();
    drive(1, 6'h23, 5'd1, 5'd3, 5'd0, 0);
    tick();
    drive(1, 6'h0d, 5'd1, 5'd3, 5'd0, 0);
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL lu_ori: got stall=%b expected 0", stall);
    end
    tick();
    checks++;
    if ({ex_valid, ex_ctrl, ex_dst} !== {1'b1, 10'b0000011010, 5'd3}) begin
      errors++;
      $display("FAIL lu_ori_ex: got %b %b %0d expected 1 0000011010 3", ex_valid, ex_ctrl, ex_dst);
    end
  endtask

  task automatic test_flush();
    do_reset();
    drive(1, 6'h23, 5'd1, 5'd3, 5'd0, 0);
    tick();
    drive(1, 6'h00, 5'd3, 5'd4, 5'd6, 1);
    #1;
    checks++;
    if ({stall, flush} !== 2'b01) begin
      errors++;
      $display("FAIL flush_prio: got stall=%b flush=%b expected 0 1", stall, flush);
    end
    tick();
    drive(0, 6'h00, 0, 0, 0, 0);
    checks++;
    if ({ex_valid, stall_count} !== 17'd0) begin
      errors++;
      $display("FAIL flush_bubble: got ex_valid=%b cnt=%0d expected 0 0", ex_valid, stall_count);
    end
  endtask

  task automatic test_zero_dst();
    do_reset();
    drive(1, 6'h08, 5'd1, 5'd0, 5'd0, 0);
    tick();
    drive(0, 6'h00, 0, 0, 0, 0);
    checks++;
    if ({ex_valid, ex_ctrl[3]} !== 2'b10) begin
      errors++;
      $display("FAIL zero_ex: got valid=%b reg_write=%b expected 1 0", ex_valid, ex_ctrl[3]);
    end
    tick();
    checks++;
    if ({mem_valid, mem_ctrl[3]} !== 2'b10) begin
      errors++;
      $display("FAIL zero_mem: got valid=%b reg_write=%b expected 1 0", mem_valid, mem_ctrl[3]);
    end
    tick();
    checks++;
    if ({wb_valid, wb_ctrl[3]} !== 2'b10) begin
      errors++;
      $display("FAIL zero_wb: got valid=%b reg_write=%b expected 1 0", wb_valid, wb_ctrl[3]);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    drive(1, 6'h3f, 5'd1, 5'd2, 5'd3, 0);
    tick();
    drive(0, 6'h00, 0, 0, 0, 0);
    checks++;
    if ({illegal_op, ex_valid, ex_ctrl} !== {1'b1, 1'b0, 10'd0}) begin
      errors++;
      $display("FAIL ill_pulse: got ill=%b ex_valid=%b ctrl=%b expected 1 0 0", illegal_op, ex_valid, ex_ctrl);
    end
    tick();
    checks++;
    if (illegal_op !== 1'b0) begin
      errors++;
      $display("FAIL ill_end: got ill=%b expected 0", illegal_op);
    end
    drive(1, 6'h05, 5'd1, 5'd2, 5'd0, 0);
    tick();
    drive(0, 6'h00, 0, 0, 0, 0);
    checks++;
    if ({a_illegal_op, a_ex_valid, illegal_op, ex_valid, ex_ctrl} !== {4'b1001, 10'b1100000001}) begin
      errors++;
      $display("FAIL ill_bne: got alt ill=%b alt ex=%b ill=%b ex=%b ctrl=%b expected 1 0 0 1 1100000001",
               a_illegal_op, a_ex_valid, illegal_op, ex_valid, ex_ctrl);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1, 6'h23, 5'd1, 5'd3, 5'd0, 0);
      tick();
      drive(1, 6'h00, 5'd3, 5'd4, 5'd6, 0);
      tick();
      drive(0, 6'h00, 0, 0, 0, 0);
      tick();
    end
    checks++;
    if ({a_stall_count, stall_count} !== {2'd3, 16'd5}) begin
      errors++;
      $display("FAIL sat: got alt=%0d main=%0d expected 3 5", a_stall_count, stall_count);
    end
  endtask

  task automatic test_random();
    logic [5:0] ops[12] = '{6'h00, 6'h08, 6'h23, 6'h21, 6'h25, 6'h2b, 6'h04, 6'h05, 6'h0c, 6'h0d, 6'h0a, 6'h3f};
    do_reset();
    for (int i = 0; i < 400; i++) begin
      reset_n = ($urandom_range(0, 49) != 0);
      drive($urandom_range(0, 7) != 0, ops[$urandom_range(0, 11)], 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), $urandom_range(0, 7) == 0);
      #1;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs_vec(k) !== exp_vec(k)) begin
          errors++;
          $display("FAIL random inst%0d cyc%0d: got %h expected %h", k, i, obs_vec(k), exp_vec(k));
        end
      end
      tick();
    end
    reset_n = 1'b1;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_ex[k] = '0; m_mem[k] = '0; m_wb[k] = '0; m_cnt[k] = 0; m_ill[k] = 0;
    end
    test_reset();
    test_addi();
    test_load_use();
    test_flush();
    test_zero_dst();
    test_illegal();
    test_saturate();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
